// File: rtl/dig_bus_arbiter2.sv
// Two-master round-robin arbiter sharing one STB/ACK/WE slave bus.
// Optional ARB_TIMEOUT_EN: force-release a grant that never sees ACK.
module dig_bus_arbiter2 #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic [AW-1:0] iM0_ADR,
  input  logic [DW-1:0] iM0_DAT,
  input  logic          iM0_WE,
  input  logic          iM0_STB,
  output logic [DW-1:0] oM0_DAT,
  output logic          oM0_ACK,
  input  logic [AW-1:0] iM1_ADR,
  input  logic [DW-1:0] iM1_DAT,
  input  logic          iM1_WE,
  input  logic          iM1_STB,
  output logic [DW-1:0] oM1_DAT,
  output logic          oM1_ACK,
  output logic [AW-1:0] oS_ADR,
  output logic [DW-1:0] oS_DAT,
  output logic          oS_WE,
  output logic          oS_STB,
  input  logic [DW-1:0] iS_DAT,
  input  logic          iS_ACK,
  output logic [1:0]    oGNT,
  output logic          oERR
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t state, state_n;
  logic   ptr, ptr_n;
  logic   g0, g1, req, done, to;

  assign g0   = (state == GNT0);
  assign g1   = (state == GNT1);
  assign oGNT = {g1, g0};
  assign req  = (g0 & iM0_STB) | (g1 & iM1_STB);
  assign done = req & (iS_ACK | to);

  // ptr holds the last master served; the other one wins a tie
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (iM0_STB && (!iM1_STB || ptr))
          state_n = GNT0;
        else if (iM1_STB)
          state_n = GNT1;
      end
      GNT0: begin
        if (!iM0_STB) begin
          state_n = IDLE;
        end else if (done) begin
          ptr_n   = 1'b0;
          state_n = iM1_STB ? GNT1 : GNT0;
        end
      end
      GNT1: begin
        if (!iM1_STB) begin
          state_n = IDLE;
        end else if (done) begin
          ptr_n   = 1'b1;
          state_n = iM0_STB ? GNT0 : GNT1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    oS_ADR  = '0;
    oS_DAT  = '0;
    oS_WE   = 1'b0;
    oS_STB  = 1'b0;
    oM0_ACK = 1'b0;
    oM0_DAT = '0;
    oM1_ACK = 1'b0;
    oM1_DAT = '0;
    unique case (1'b1)
      g0: begin
        oS_ADR  = iM0_ADR;
        oS_DAT  = iM0_DAT;
        oS_WE   = iM0_WE;
        oS_STB  = iM0_STB & ~to;
        oM0_ACK = iS_ACK | to;
        oM0_DAT = to ? DW'(32'hDEAD_BEEF) :
                  (iM0_WE ? '0 : iS_DAT);
      end
      g1: begin
        oS_ADR  = iM1_ADR;
        oS_DAT  = iM1_DAT;
        oS_WE   = iM1_WE;
        oS_STB  = iM1_STB & ~to;
        oM1_ACK = iS_ACK | to;
        oM1_DAT = to ? DW'(32'hDEAD_BEEF) :
                  (iM1_WE ? '0 : iS_DAT);
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // the strobe is withheld in the timeout cycle, so no ACK loop exists
  assign to   = req & (cnt == 8'(TIMEOUT_CYC - 1));
  assign oERR = to;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)
      cnt <= '0;
    else if (state == IDLE || state_n != state || done)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end
`else
  logic unused_cfg;

  assign to         = 1'b0;
  assign oERR       = 1'b0;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_dig_bus_arbiter2.sv
// Bench for dig_bus_arbiter2: vector table, corner sequences,
// and randomized two-master traffic against a memory/fairness model.
module tb_dig_bus_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m0_rdat;
  logic [31:0] m1_adr, m1_dat, m1_rdat;
  logic        m0_we, m0_stb, m0_ack;
  logic        m1_we, m1_stb, m1_ack;
  logic [31:0] s_adr, s_dat, s_rdat;
  logic        s_we, s_stb, s_ack;
  logic [1:0]  gnt;
  logic        err;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs[256];
  bit          written[256];
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  dig_bus_arbiter2 dut (
    .iCLK(clk), .iRSTn(rst_n),
    .iM0_ADR(m0_adr), .iM0_DAT(m0_dat), .iM0_WE(m0_we),
    .iM0_STB(m0_stb), .oM0_DAT(m0_rdat), .oM0_ACK(m0_ack),
    .iM1_ADR(m1_adr), .iM1_DAT(m1_dat), .iM1_WE(m1_we),
    .iM1_STB(m1_stb), .oM1_DAT(m1_rdat), .oM1_ACK(m1_ack),
    .oS_ADR(s_adr), .oS_DAT(s_dat), .oS_WE(s_we),
    .oS_STB(s_stb), .iS_DAT(s_rdat), .iS_ACK(s_ack),
    .oGNT(gnt), .oERR(err)
  );

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return (a == 8'h20) ? 32'h0000_00A5 : (32'hC0DE_0000 | {24'h0, a});
  endfunction

  function automatic logic [31:0] rd(input logic [7:0] a);
    return written[a] ? regs[a] : dflt(a);
  endfunction

  // slave: combinational ACK, junk on the data bus when not strobed
  assign s_ack  = ack_en & s_stb;
  assign s_rdat = s_stb ? rd(s_adr[7:0]) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (s_stb && s_we && s_ack) begin
      regs[s_adr[7:0]]    <= s_dat;
      written[s_adr[7:0]] <= 1'b1;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d;
    end else begin
      m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ack_en = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s0, w0;
    logic [31:0] a0, d0;
    logic        s1, w1;
    logic [31:0] a1, d1;
    logic        ack;
    logic [1:0]  gnt;
    logic        k0, k1;
    logic [31:0] r0, r1, sadr, sdat;
    logic        sstb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n  = 1'b0;
    ack_en = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h10, 32'h5A);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sstb", 32'(s_stb), 32'h0);
    chk("rst_ack0", 32'(m0_ack), 32'h0);
    chk("rst_ack1", 32'(m1_ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    tbl[0] = '{1'b1, 1'b1, 32'h10, 32'h5A, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b1, 2'b01, 1'b1, 1'b0,
               32'h0, 32'h0, 32'h10, 32'h5A, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h77,
               1'b1, 2'b10, 1'b0, 1'b1,
               32'h0, 32'hA5, 32'h20, 32'h77, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h30, 32'h11, 1'b1, 1'b1, 32'h31, 32'h99,
               1'b1, 2'b01, 1'b1, 1'b0,
               32'hC0DE_0030, 32'h0, 32'h30, 32'h11, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h40, 32'h22, 1'b1, 1'b0, 32'h41, 32'h0,
               1'b0, 2'b01, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h40, 32'h22, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h55, 32'h66, 1'b0, 1'b1, 32'h57, 32'h88,
               1'b1, 2'b00, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0,
               1'b0, 2'b10, 1'b0, 1'b0,
               32'h0, 32'hC0DE_0050, 32'h50, 32'h0, 1'b1};

    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ack_en = tbl[i].ack;
      drive(0, tbl[i].s0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      drive(1, tbl[i].s1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk("v_latency_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      chk("v_gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("v_ack0", 32'(m0_ack), 32'(tbl[i].k0));
      chk("v_ack1", 32'(m1_ack), 32'(tbl[i].k1));
      chk("v_rdat0", m0_rdat, tbl[i].r0);
      chk("v_rdat1", m1_rdat, tbl[i].r1);
      chk("v_sadr", s_adr, tbl[i].sadr);
      chk("v_sdat", s_dat, tbl[i].sdat);
      chk("v_sstb", 32'(s_stb), 32'(tbl[i].sstb));
      chk("v_err", 32'(err), 32'h0);
      @(posedge clk);
      #1;
      m0_stb = 1'b0;
      m1_stb = 1'b0;
      @(negedge clk);
      chk("v_drop_sstb", 32'(s_stb), 32'h0);
      @(negedge clk);
      chk("v_idle_gnt", 32'(gnt), 32'h0);
    end
    chk("reg_b", regs[8'h10], 32'h5A);
    chk("tbl_writes", 32'(wr_cnt - w0), 32'd1);

    // both held from reset: M0 first, then strict alternation
    do_reset();
    ack_en = 1'b1;
    w0 = wr_cnt;
    drive(0, 1'b1, 1'b1, 32'h44, 32'h1);
    drive(1, 1'b1, 1'b1, 32'h45, 32'h2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_ack", 32'({m1_ack, m0_ack}),
          (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    @(posedge clk);
    #1;
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    chk("alt_writes", 32'(wr_cnt - w0), 32'd4);

    // abort: STB dropped without ACK, pointer left alone
    do_reset();
    w0 = wr_cnt;
    drive(0, 1'b1, 1'b1, 32'h60, 32'h66);
    @(negedge clk);
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h1);
    chk("abort_sstb", 32'(s_stb), 32'h1);
    @(posedge clk);
    #1 m0_stb = 1'b0;
    @(negedge clk);
    chk("abort_sstb_off", 32'(s_stb), 32'h0);
    chk("abort_ack", 32'(m0_ack), 32'h0);
    @(negedge clk);
    chk("abort_idle", 32'(gnt), 32'h0);
    chk("abort_nowrite", 32'(wr_cnt - w0), 32'd0);
    drive(0, 1'b1, 1'b0, 32'h61, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h62, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ptr_kept", 32'(gnt), 32'h1);

    // asynchronous reset in the middle of a granted transfer
    do_reset();
    drive(0, 1'b1, 1'b1, 32'h70, 32'h77);
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_gnt", 32'(gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sstb", 32'(s_stb), 32'h0);
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_ack", 32'(m0_ack), 32'h0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    drive(0, 1'b1, 1'b1, 32'h90, 32'h9);
    drive(1, 1'b1, 1'b1, 32'h91, 32'hA);
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) begin
        chk("to_wait_ack", 32'(m0_ack), 32'h0);
        chk("to_wait_err", 32'(err), 32'h0);
      end else begin
        chk("to_ack", 32'(m0_ack), 32'h1);
        chk("to_dat", m0_rdat, 32'hDEAD_BEEF);
        chk("to_err", 32'(err), 32'h1);
        chk("to_sstb", 32'(s_stb), 32'h0);
      end
    end
    @(posedge clk);
    #1;
    m0_stb = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    chk("to_next_gnt", 32'(gnt), 32'h2);
    chk("to_next_ack", 32'(m1_ack), 32'h1);
    chk("to_next_err", 32'(err), 32'h0);
`endif

    begin
      logic [31:0] mem[int];
      int  gap[2], age[2], acks[2];
      bit  held[2], st[2], ak[2], we[2], dn[2];
      logic [31:0] ad[2], dt[2], rv[2];
      int  last, wacks;
      bit  stuck;
      do_reset();
      ack_en = 1'b1;
      w0 = wr_cnt;
      last = -1;
      wacks = 0;
      stuck = 1'b0;
      for (int m = 0; m < 2; m++) begin
        gap[m] = $urandom_range(1, 3);
        age[m] = 0;
        acks[m] = 0;
        held[m] = 1'b0;
      end
      for (int cyc = 0; cyc < 3000 && !stuck; cyc++) begin
        @(negedge clk);
        st = '{m0_stb, m1_stb};
        ak = '{m0_ack, m1_ack};
        we = '{m0_we, m1_we};
        ad = '{m0_adr, m1_adr};
        dt = '{m0_dat, m1_dat};
        rv = '{m0_rdat, m1_rdat};
        chk("rand_onehot", 32'(gnt == 2'b11), 32'h0);
        for (int m = 0; m < 2; m++) begin
          held[m] = held[m] & st[m];
          dn[m] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
          if (ak[m] && !st[m])
            chk("rand_spurious_ack", 32'(ak[m]), 32'h0);
          if (st[m] && ak[m]) begin
            int a;
            a = int'(ad[m][7:0]);
            if (!we[m]) begin
              chk("rand_rdata", rv[m],
                  mem.exists(a) ? mem[a] : dflt(ad[m][7:0]));
            end else begin
              mem[a] = dt[m];
              wacks++;
            end
            chk("rand_fair", 32'(last == m && held[1-m]), 32'h0);
            last = m;
            held[1-m] = st[1-m];
            dn[m] = 1'b1;
            acks[m]++;
            age[m] = 0;
          end else if (st[m]) begin
            age[m]++;
            if (age[m] > 20) begin
              chk("rand_timeout", 32'(age[m]), 32'd20);
              stuck = 1'b1;
            end
          end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
          if (dn[m] || !st[m]) begin
            if (dn[m])
              gap[m] = $urandom_range(0, 2);
            else if (gap[m] > 0)
              gap[m]--;
            if (gap[m] == 0)
              drive(m, 1'b1, 1'($urandom_range(0, 1)),
                    32'h80 + 32'($urandom_range(0, 7)), $urandom);
            else
              drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
          end
        end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("rand_writes", 32'(wr_cnt - w0), 32'(wacks));
      chk("rand_m0_served", 32'(acks[0] > 100), 32'h1);
      chk("rand_m1_served", 32'(acks[1] > 100), 32'h1);
      foreach (mem[k])
        chk("rand_mem", regs[k], mem[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
